// File: rtl/hw_output_stream_collector.sv
// Buffers a non-stallable accelerator output stream in a FWFT FIFO, tags each word with
// end-of-row / end-of-frame flags and drains it over a valid/ready interface.
module hw_output_stream_collector #(
    parameter int DATA_W     = 16,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last_col,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_active,
    output logic                          overflow,
    output logic                          frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int EW = DATA_W + 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            overflow_q;
    logic            frame_done_q;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic            eol_s, eof_s;
    logic            full_s, empty_s;
    logic            push_s, pop_s, drop_s;
    logic [EW-1:0]   head_s;

    assign eol_s   = (col_q == CW'(IMG_W - 1));
    assign eof_s   = eol_s && (row_q == RW'(IMG_H - 1));
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];
    // Pop needs a present head, so a push/pop at empty degenerates to a plain push.
    assign pop_s   = !empty_s && out_ready;
    assign push_s  = in_valid && (!full_s || pop_s);
    assign drop_s  = in_valid && full_s && !pop_s;

    // Position counters and frame FSM next state; both advance on every input word, stored or not.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (in_valid) begin
            if (eol_s) begin
                col_d = {CW{1'b0}};
                row_d = eof_s ? {RW{1'b0}} : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            case (state_q)
                ST_IDLE:   state_d = eof_s ? ST_IDLE : ST_ACTIVE;
                ST_ACTIVE: state_d = eof_s ? ST_IDLE : ST_ACTIVE;
                default:   state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control state: pointers, counters, FSM, sticky overflow and frame-done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            state_q      <= ST_IDLE;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_q + PW'(push_s);
            rd_ptr_q     <= rd_ptr_q + PW'(pop_s);
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            frame_done_q <= pop_s && head_s[0];
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array; empty-FIFO outputs are masked, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_data, eol_s, eof_s};
        end
    end

    assign out_valid    = !empty_s;
    assign out_data     = out_valid ? head_s[EW-1:2] : {DATA_W{1'b0}};
    assign out_last_col = out_valid && head_s[1];
    assign out_last     = out_valid && head_s[0];
    assign level        = wr_ptr_q - rd_ptr_q;
    assign frame_active = (state_q == ST_ACTIVE);
    assign overflow     = overflow_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_hw_output_stream_collector.sv
// Randomized and directed bench for hw_output_stream_collector against a queue-based model.
module tb_hw_output_stream_collector;
    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          out_valid, out_last_col, out_last, frame_active, overflow, frame_done;
    logic [DW-1:0] out_data;
    logic [4:0]    level;

    always #5 clk = ~clk;

    hw_output_stream_collector #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_last_col(out_last_col),
        .out_last(out_last), .out_ready(out_ready), .level(level),
        .frame_active(frame_active), .overflow(overflow), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          eol;
        logic          eof;
    } ent_t;

    ent_t          mq[$];
    int            pix = 0;
    bit            m_ovf = 1'b0;
    bit            m_fd = 1'b0;
    bit            started = 1'b0;
    logic [DW-1:0] log_q[$];
    int            fd_cnt = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pixel index within frame gives tags; frame is active whenever index is nonzero.
    always @(posedge clk) begin : model
        bit   pop;
        ent_t e;
        if (rst) begin
            mq.delete(); pix = 0; m_ovf = 1'b0; m_fd = 1'b0; started = 1'b1;
        end else if (flush) begin
            mq.delete(); pix = 0; m_fd = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            m_fd = pop && mq[0].eof;
            if (in_valid) begin
                e.d   = in_data;
                e.eol = ((pix % W) == W - 1);
                e.eof = (pix == W * H - 1);
            end
            if (pop) void'(mq.pop_front());
            if (in_valid) begin
                if (mq.size() < D) mq.push_back(e);
                else m_ovf = 1'b1;
                pix = (pix + 1) % (W * H);
            end
        end
    end

    // Compare DUT against the model every cycle and log observed handshakes.
    always @(negedge clk) begin : cmp
        bit ev;
        if (started) begin
            ev = (mq.size() > 0);
            check("out_valid", out_valid, ev);
            check("out_data", out_data, ev ? mq[0].d : 0);
            check("out_last_col", out_last_col, ev ? mq[0].eol : 0);
            check("out_last", out_last, ev ? mq[0].eof : 0);
            check("level", level, mq.size());
            check("frame_active", frame_active, pix != 0);
            check("overflow", overflow, m_ovf);
            check("frame_done", frame_done, m_fd);
            if (frame_done === 1'b1) fd_cnt++;
            if (out_valid && out_ready && !rst && !flush) log_q.push_back(out_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic expect_log(string nm, int first, int n);
        check({nm, "_count"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) check(nm, log_q[i], first + i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_active", frame_active, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", frame_done, 0);

        // T1: single frame streams straight through.
        log_q.delete(); fd_cnt = 0; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(DW'(i));
        repeat (4) cyc();
        expect_log("t1_data", 1, 8);
        check("t1_frame_done_cnt", fd_cnt, 1);
        check("t1_overflow", overflow, 0);

        // T2: fill, drop one, drain.
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push(DW'(i));
        check("t2_level_full", level, 16);
        push(DW'(17));
        check("t2_overflow", overflow, 1);
        check("t2_level_after_drop", level, 16);
        log_q.delete(); out_ready = 1'b1;
        repeat (20) cyc();
        check("t2_level_drained", level, 0);
        check("t2_overflow_sticky", overflow, 1);
        expect_log("t2_data", 1, 16);

        // T4: flush clears buffer and position, keeps overflow.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'(16'h0300 + i));
        flush = 1'b1; cyc(); flush = 1'b0;
        check("t4_level", level, 0);
        check("t4_valid", out_valid, 0);
        check("t4_overflow", overflow, 1);
        push(16'hA5A5);
        check("t4_head", out_data, 16'hA5A5);
        check("t4_head_eol", out_last_col, 0);
        check("t4_active", frame_active, 1);
        for (int i = 0; i < 3; i++) push(DW'(16'h0400 + i));

        // T5: reset mid-frame with five words buffered.
        push(16'h0500);
        check("t5_level", level, 5);
        do_reset();
        check("t5_valid", out_valid, 0);
        check("t5_data", out_data, 0);
        check("t5_last", out_last, 0);
        check("t5_level0", level, 0);
        check("t5_active", frame_active, 0);
        check("t5_overflow", overflow, 0);
        push(16'h0042);
        check("t5_first_head", out_data, 16'h0042);
        check("t5_first_active", frame_active, 1);
        out_ready = 1'b1;
        repeat (3) cyc();

        // T3: push and pop together at full.
        do_reset();
        out_ready = 1'b0;
        for (int i = 101; i <= 116; i++) push(DW'(i));
        check("t3_full", level, 16);
        in_valid = 1'b1; in_data = DW'(200); out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        check("t3_level", level, 16);
        check("t3_no_drop", overflow, 0);
        check("t3_head", out_data, 102);
        log_q.delete(); out_ready = 1'b1;
        repeat (20) cyc();
        check("t3_count", log_q.size(), 16);
        if (log_q.size() == 16) begin
            check("t3_first", log_q[0], 102);
            check("t3_tail", log_q[15], 200);
        end

        // T6: two back-to-back frames with random backpressure.
        do_reset();
        log_q.delete(); fd_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = DW'(i); out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) cyc();
        expect_log("t6_data", 1, 16);
        check("t6_frame_done_cnt", fd_cnt, 2);

        // Random soak with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = DW'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            rst       = ($urandom % 200) == 0;
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
